led_stream_decoder: RTL and testbench
=====================================

LED_STREAM_DECODER -- requirements
Module: led_stream_decoder

Interface
REQ-001 SHALL have parameter BITS_PER_LED, default 24, bits per LED word (24 RGB, 32 RGBW).
REQ-002 SHALL have parameter NUM_CAPTURE, default 1, number of LED words captured per frame before passthrough.
REQ-003 SHALL have parameter BIT_THRESH, default 40, high-time in cycles at or above which a bit decodes as 1.
REQ-004 SHALL have parameter HIGH_MAX, default 200, high-time in cycles above which the pulse is a protocol error.
REQ-005 SHALL have parameter RESET_CYCLES, default 2500, low-time in cycles that marks end of frame (latch).
REQ-006 SHALL have parameter CNT_WIDTH, default 12, pulse-counter width; legal only if BIT_THRESH < HIGH_MAX < RESET_CYCLES < 2^CNT_WIDTH-1.
REQ-007 i_clk  input  1  single clock; all logic rising-edge.
REQ-008 i_reset_n  input  1  asynchronous active-low reset.
REQ-009 i_signal_syncd  input  1  serial LED stream, already synchronized to i_clk.
REQ-010 o_led_data  output  NUM_CAPTURE*BITS_PER_LED  last complete captured frame; first-received bit at MSB.
REQ-011 o_data_valid  output  1  one-cycle pulse when o_led_data updates.
REQ-012 o_passthru_en  output  1  high while later bits are forwarded downstream.
REQ-013 o_dout  output  1  regenerated downstream stream.
REQ-014 o_frame_error  output  1  one-cycle pulse on protocol error or truncated frame.

Function
REQ-015 States SHALL be SYNC (wait for initial latch), CAPTURE, PASSTHRU, ERROR.
REQ-016 high_cnt SHALL load 1 on first high sample, increment while high, saturate at 2^CNT_WIDTH-1.
REQ-017 low_cnt SHALL load 1 on first low sample, increment while low, saturate at 2^CNT_WIDTH-1.
REQ-018 latch event SHALL fire exactly once per low period, on the cycle low_cnt reaches RESET_CYCLES.
REQ-019 SYNC: all edges ignored; latch -> CAPTURE with bit counter cleared.
REQ-020 CAPTURE: on first low sample after high, bit = (high_cnt >= BIT_THRESH), shifted in at LSB of capture register, bit counter +1.
REQ-021 CAPTURE: when bit counter reaches NUM_CAPTURE*BITS_PER_LED, next cycle SHALL load o_led_data, pulse o_data_valid, enter PASSTHRU.
REQ-022 CAPTURE: latch with 0 bits received -> stay CAPTURE, no error; latch with 1..N-1 bits -> pulse o_frame_error, discard partial, o_led_data unchanged, bit counter cleared.
REQ-023 Any state except SYNC: high_cnt exceeding HIGH_MAX -> pulse o_frame_error once, enter ERROR, discard partial data.
REQ-024 ERROR: edges ignored; latch -> CAPTURE.
REQ-025 PASSTHRU: o_passthru_en=1, o_dout = i_signal_syncd delayed exactly 1 cycle; latch -> CAPTURE, o_passthru_en=0 same cycle.
REQ-026 o_dout SHALL be 0 outside PASSTHRU; the last captured bit SHALL NOT appear on o_dout.
REQ-027 Falling edge and HIGH_MAX violation cannot coincide; if last bit and latch arrive in the same cycle, valid takes priority and state goes CAPTURE.
REQ-028 o_led_data SHALL hold its value until the next complete frame.

Reset
REQ-029 On i_reset_n low: state SYNC, counters 0, capture register 0, o_led_data 0, o_data_valid 0, o_passthru_en 0, o_dout 0, o_frame_error 0.
REQ-030 Reset mid-frame SHALL discard partial data; after release a full RESET_CYCLES low period is needed before capture.

Verification (defaults; bit 1 = 60 high/65 low, bit 0 = 20 high/105 low)
REQ-031 Low 2500 cycles, then 24 bits 0xA5C3F0 -> single o_data_valid, o_led_data=0xA5C3F0, o_passthru_en=1, no error.
REQ-032 After REQ-031, 24 more bits 0x123456 -> o_dout equals input delayed 1 cycle, o_led_data stays 0xA5C3F0; low 2500 -> o_passthru_en=0 at cycle 2500.
REQ-033 10 bits then low 2500 -> one o_frame_error pulse, no o_data_valid, o_led_data unchanged; next 24-bit frame captured correctly.
REQ-034 High held 250 cycles mid-capture -> o_frame_error at high_cnt=201, bits ignored until low 2500, then normal capture.
REQ-035 Bits sent without initial low 2500 after reset -> ignored; i_reset_n pulsed after 12 bits -> all outputs 0, SYNC re-entered.
REQ-036 NUM_CAPTURE=2, BITS_PER_LED=32: 64 bits 0xDEADBEEF_01020304 -> o_led_data=0xDEADBEEF01020304, then passthrough.

Source files
------------

// File: rtl/led_stream_decoder.sv
// Decodes a WS281x-style pulse-width LED stream: captures the first NUM_CAPTURE
// LED words of each frame, then regenerates the remaining bits downstream.
module led_stream_decoder #(
    parameter int BITS_PER_LED = 24,
    parameter int NUM_CAPTURE  = 1,
    parameter int BIT_THRESH   = 40,
    parameter int HIGH_MAX     = 200,
    parameter int RESET_CYCLES = 2500,
    parameter int CNT_WIDTH    = 12
) (
    input  logic                                i_clk,
    input  logic                                i_reset_n,
    input  logic                                i_signal_syncd,
    output logic [NUM_CAPTURE*BITS_PER_LED-1:0] o_led_data,
    output logic                                o_data_valid,
    output logic                                o_passthru_en,
    output logic                                o_dout,
    output logic                                o_frame_error
);

    localparam int TOTAL = NUM_CAPTURE * BITS_PER_LED;
    localparam int BCW   = $clog2(TOTAL + 1);

    localparam logic [CNT_WIDTH-1:0] C_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] C_THRESH = CNT_WIDTH'(BIT_THRESH);
    localparam logic [CNT_WIDTH-1:0] C_HOVER  = CNT_WIDTH'(HIGH_MAX + 1);
    localparam logic [CNT_WIDTH-1:0] C_RESET  = CNT_WIDTH'(RESET_CYCLES);
    localparam logic [BCW-1:0]       C_TOTAL  = BCW'(TOTAL);

    typedef enum logic [1:0] {SYNC, CAPTURE, PASSTHRU, ERROR} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_sig_d;
    logic [CNT_WIDTH-1:0] r_high_cnt;
    logic [CNT_WIDTH-1:0] r_low_cnt;
    logic [CNT_WIDTH-1:0] w_high_next;
    logic [CNT_WIDTH-1:0] w_low_next;
    logic [TOTAL-1:0]     r_shift;
    logic [BCW-1:0]       r_bit_cnt;
    logic [TOTAL-1:0]     r_led_data;
    logic                 r_data_valid;
    logic                 r_frame_error;

    logic w_fall;
    logic w_latch;
    logic w_hover;
    logic w_bit;
    logic w_load;
    logic w_shift;
    logic w_clr;
    logic w_err;

    // Pulse timers: each loads 1 on its level's first sample and holds otherwise,
    // so the high time is still available on the first low sample.
    always_comb begin
        w_high_next = r_high_cnt;
        w_low_next  = r_low_cnt;
        if (i_signal_syncd) begin
            if (!r_sig_d)
                w_high_next = C_ONE;
            else if (r_high_cnt != '1)
                w_high_next = r_high_cnt + 1'b1;
        end else begin
            if (r_sig_d)
                w_low_next = C_ONE;
            else if (r_low_cnt != '1)
                w_low_next = r_low_cnt + 1'b1;
        end
    end

    assign w_fall  = r_sig_d & ~i_signal_syncd;
    assign w_latch = ~i_signal_syncd & (w_low_next == C_RESET);
    assign w_hover = i_signal_syncd & (w_high_next == C_HOVER);
    assign w_bit   = (r_high_cnt >= C_THRESH);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sig_d    <= 1'b0;
            r_high_cnt <= '0;
            r_low_cnt  <= '0;
        end else begin
            r_sig_d    <= i_signal_syncd;
            r_high_cnt <= w_high_next;
            r_low_cnt  <= w_low_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            r_state <= SYNC;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_clr        = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            SYNC: begin
                if (w_latch) begin
                    w_state_next = CAPTURE;
                    w_clr        = 1'b1;
                end
            end
            CAPTURE: begin
                // A completed word wins over a coincident latch, which then just restarts capture.
                if (r_bit_cnt == C_TOTAL) begin
                    w_load       = 1'b1;
                    w_clr        = 1'b1;
                    w_state_next = w_latch ? CAPTURE : PASSTHRU;
                end else if (w_hover) begin
                    w_err        = 1'b1;
                    w_clr        = 1'b1;
                    w_state_next = ERROR;
                end else if (w_latch) begin
                    w_err = (r_bit_cnt != '0);
                    w_clr = 1'b1;
                end else if (w_fall) begin
                    w_shift = 1'b1;
                end
            end
            PASSTHRU: begin
                if (w_hover) begin
                    w_err        = 1'b1;
                    w_clr        = 1'b1;
                    w_state_next = ERROR;
                end else if (w_latch) begin
                    w_clr        = 1'b1;
                    w_state_next = CAPTURE;
                end
            end
            ERROR: begin
                if (w_hover) begin
                    w_err = 1'b1;
                end else if (w_latch) begin
                    w_clr        = 1'b1;
                    w_state_next = CAPTURE;
                end
            end
            default: w_state_next = SYNC;
        endcase
    end

    always_comb begin
        o_passthru_en = (r_state == PASSTHRU);
        o_dout        = (r_state == PASSTHRU) & r_sig_d;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_led_data    <= '0;
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_data_valid  <= w_load;
            r_frame_error <= w_err;
            if (w_load)
                r_led_data <= r_shift;
            if (w_clr) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_shift   <= {r_shift[TOTAL-2:0], w_bit};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    assign o_led_data    = r_led_data;
    assign o_data_valid  = r_data_valid;
    assign o_frame_error = r_frame_error;

endmodule

// File: tb/tb_led_stream_decoder.sv
// Self-checking bench for led_stream_decoder: default 24-bit instance plus a
// 2x32-bit instance, driven with fixed and randomly jittered pulse trains.
module tb_led_stream_decoder;

    localparam int BIT_THRESH = 40;

    logic        clk;
    logic        rst_n;
    logic        sig;
    logic        sig2;
    logic [23:0] led;
    logic        valid, pass, dout, ferr;
    logic [63:0] led2;
    logic        valid2, pass2, dout2, ferr2;

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor tallies, cleared by the tests.
    int          n_valid, n_err, dout_bad, dout_ones;
    int          n_valid2, n_err2, dout_bad2, dout_ones2;
    logic [63:0] last_data, last_data2;

    led_stream_decoder dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_signal_syncd(sig),
        .o_led_data(led), .o_data_valid(valid), .o_passthru_en(pass),
        .o_dout(dout), .o_frame_error(ferr)
    );

    led_stream_decoder #(.BITS_PER_LED(32), .NUM_CAPTURE(2)) dut2 (
        .i_clk(clk), .i_reset_n(rst_n), .i_signal_syncd(sig2),
        .o_led_data(led2), .o_data_valid(valid2), .o_passthru_en(pass2),
        .o_dout(dout2), .o_frame_error(ferr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Just after each edge the input level is the one sampled there, which the
    // regenerated output must now show.
    always begin
        @(posedge clk);
        #1;
        if (valid) begin n_valid++; last_data = 64'(led); end
        if (ferr) n_err++;
        if (pass) begin
            if (dout !== sig) dout_bad++;
            if (dout === 1'b1) dout_ones++;
        end else if (dout !== 1'b0) dout_bad++;
        if (valid2) begin n_valid2++; last_data2 = led2; end
        if (ferr2) n_err2++;
        if (pass2) begin
            if (dout2 !== sig2) dout_bad2++;
            if (dout2 === 1'b1) dout_ones2++;
        end else if (dout2 !== 1'b0) dout_bad2++;
    end

    task automatic clear_mon();
        n_valid = 0; n_err = 0; dout_bad = 0; dout_ones = 0;
        n_valid2 = 0; n_err2 = 0; dout_bad2 = 0; dout_ones2 = 0;
    endtask

    task automatic drv(input int w, input logic v, input int n);
        if (w == 0) sig = v; else sig2 = v;
        repeat (n) @(negedge clk);
    endtask

    // Sends nbits MSB first. Nominal timing is 60/65 for a 1 and 20/105 for a 0;
    // jitter draws random timings. The model value is rebuilt from the high times.
    task automatic send_bits(input int w, input logic [63:0] data, input int nbits,
                             input bit jitter, input int last_low,
                             output logic [63:0] model, output int hsum);
        int h, l;
        model = '0;
        hsum  = 0;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (jitter) begin
                h = data[i] ? int'($urandom_range(45, 90)) : int'($urandom_range(8, 30));
                l = int'($urandom_range(40, 70));
            end else begin
                h = data[i] ? 60 : 20;
                l = data[i] ? 65 : 105;
            end
            if (i == 0) l = last_low;
            model = (model << 1) | 64'(h >= BIT_THRESH);
            hsum += h;
            drv(w, 1'b1, h);
            if (l > 0) drv(w, 1'b0, l);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sig = 1'b0; sig2 = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if ({led, valid, pass, dout, ferr} !== '0) begin n_fail++; $display("FAIL reset_outputs got %h exp 0", {led, valid, pass, dout, ferr}); end
        n_tests++; if ({led2, valid2, pass2, dout2, ferr2} !== '0) begin n_fail++; $display("FAIL reset_outputs2 got %h exp 0", {led2, valid2, pass2, dout2, ferr2}); end
        rst_n = 1'b1;
    endtask

    task automatic test_capture();
        logic [63:0] m; int hs;
        clear_mon();
        drv(0, 1'b0, 2500);
        send_bits(0, 64'hA5C3F0, 24, 1'b0, 105, m, hs);
        n_tests++; if (m !== 64'hA5C3F0) begin n_fail++; $display("FAIL cap_model got %h exp a5c3f0", m); end
        n_tests++; if (led !== 24'hA5C3F0) begin n_fail++; $display("FAIL cap_data got %h exp a5c3f0", led); end
        n_tests++; if (n_valid !== 1) begin n_fail++; $display("FAIL cap_valid_count got %0d exp 1", n_valid); end
        n_tests++; if (pass !== 1'b1) begin n_fail++; $display("FAIL cap_passthru got %b exp 1", pass); end
        n_tests++; if (n_err !== 0 || dout_bad !== 0 || dout_ones !== 0) begin n_fail++; $display("FAIL cap_quiet got err=%0d bad=%0d ones=%0d exp 0", n_err, dout_bad, dout_ones); end
    endtask

    task automatic test_passthru();
        logic [63:0] m; int hs;
        clear_mon();
        send_bits(0, 64'h123456, 24, 1'b0, 0, m, hs);
        drv(0, 1'b0, 2499);
        n_tests++; if (pass !== 1'b1) begin n_fail++; $display("FAIL pt_before_latch got %b exp 1", pass); end
        drv(0, 1'b0, 1);
        n_tests++; if (pass !== 1'b0) begin n_fail++; $display("FAIL pt_at_latch got %b exp 0", pass); end
        n_tests++; if (dout_bad !== 0) begin n_fail++; $display("FAIL pt_dout_follow got %0d bad cycles exp 0", dout_bad); end
        n_tests++; if (dout_ones !== hs) begin n_fail++; $display("FAIL pt_dout_ones got %0d exp %0d", dout_ones, hs); end
        n_tests++; if (led !== 24'hA5C3F0 || n_valid !== 0) begin n_fail++; $display("FAIL pt_data_hold got %h/%0d exp a5c3f0/0", led, n_valid); end
    endtask

    task automatic test_truncated();
        logic [63:0] m; int hs;
        clear_mon();
        send_bits(0, 64'($urandom), 10, 1'b1, 2500, m, hs);
        n_tests++; if (ferr !== 1'b1) begin n_fail++; $display("FAIL trunc_err_at_latch got %b exp 1", ferr); end
        drv(0, 1'b0, 5);
        n_tests++; if (n_err !== 1 || n_valid !== 0) begin n_fail++; $display("FAIL trunc_counts got err=%0d valid=%0d exp 1/0", n_err, n_valid); end
        n_tests++; if (led !== 24'hA5C3F0) begin n_fail++; $display("FAIL trunc_data_hold got %h exp a5c3f0", led); end
        send_bits(0, 64'($urandom_range(0, 24'hFFFFFF)), 24, 1'b1, 60, m, hs);
        n_tests++; if (led !== m[23:0] || n_valid !== 1) begin n_fail++; $display("FAIL trunc_next_frame got %h/%0d exp %h/1", led, n_valid, m[23:0]); end
        drv(0, 1'b0, 2500);
    endtask

    task automatic test_high_max();
        logic [63:0] m; int hs;
        clear_mon();
        send_bits(0, 64'($urandom), 8, 1'b1, 60, m, hs);
        drv(0, 1'b1, 200);
        n_tests++; if (ferr !== 1'b0 || n_err !== 0) begin n_fail++; $display("FAIL hmax_at_200 got %b/%0d exp 0/0", ferr, n_err); end
        drv(0, 1'b1, 1);
        n_tests++; if (ferr !== 1'b1) begin n_fail++; $display("FAIL hmax_at_201 got %b exp 1", ferr); end
        drv(0, 1'b1, 49);
        drv(0, 1'b0, 100);
        send_bits(0, 64'($urandom), 5, 1'b1, 60, m, hs);
        n_tests++; if (n_err !== 1 || n_valid !== 0) begin n_fail++; $display("FAIL hmax_ignored got err=%0d valid=%0d exp 1/0", n_err, n_valid); end
        drv(0, 1'b0, 2500);
        send_bits(0, 64'($urandom_range(0, 24'hFFFFFF)), 24, 1'b1, 60, m, hs);
        n_tests++; if (led !== m[23:0] || n_valid !== 1 || n_err !== 1) begin n_fail++; $display("FAIL hmax_recover got %h/%0d/%0d exp %h/1/1", led, n_valid, n_err, m[23:0]); end
        drv(0, 1'b0, 2500);
    endtask

    task automatic test_sync_reset();
        logic [63:0] m; int hs;
        sig = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++; if ({led, valid, pass, dout, ferr} !== '0) begin n_fail++; $display("FAIL rst_clears got %h exp 0", {led, valid, pass, dout, ferr}); end
        rst_n = 1'b1;
        clear_mon();
        drv(0, 1'b0, 2499);
        send_bits(0, 64'($urandom_range(0, 24'hFFFFFF)), 24, 1'b1, 60, m, hs);
        n_tests++; if (n_valid !== 0 || n_err !== 0 || pass !== 1'b0) begin n_fail++; $display("FAIL sync_short_low got valid=%0d err=%0d pass=%b exp 0", n_valid, n_err, pass); end
        drv(0, 1'b0, 2500);
        send_bits(0, 64'($urandom), 12, 1'b1, 30, m, hs);
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++; if ({led, valid, pass, dout, ferr} !== '0) begin n_fail++; $display("FAIL rst_midframe got %h exp 0", {led, valid, pass, dout, ferr}); end
        rst_n = 1'b1;
        clear_mon();
        send_bits(0, 64'($urandom_range(0, 24'hFFFFFF)), 24, 1'b1, 60, m, hs);
        n_tests++; if (n_valid !== 0 || n_err !== 0 || led !== 24'h0) begin n_fail++; $display("FAIL sync_no_latch got valid=%0d err=%0d led=%h exp 0", n_valid, n_err, led); end
        drv(0, 1'b0, 2500);
        send_bits(0, 64'($urandom_range(0, 24'hFFFFFF)), 24, 1'b1, 60, m, hs);
        n_tests++; if (led !== m[23:0] || n_valid !== 1) begin n_fail++; $display("FAIL sync_capture got %h/%0d exp %h/1", led, n_valid, m[23:0]); end
    endtask

    task automatic test_random();
        logic [63:0] m, mf; int hs;
        for (int k = 0; k < 2; k++) begin
            drv(0, 1'b0, 2500);
            clear_mon();
            send_bits(0, 64'($urandom_range(0, 24'hFFFFFF)), 24, 1'b1, 60, m, hs);
            n_tests++; if (led !== m[23:0] || last_data !== m || n_valid !== 1) begin n_fail++; $display("FAIL rnd_capture got %h/%0d exp %h/1", led, n_valid, m[23:0]); end
            send_bits(0, 64'($urandom), 24, 1'b1, 60, mf, hs);
            n_tests++; if (dout_ones !== hs || dout_bad !== 0) begin n_fail++; $display("FAIL rnd_forward got ones=%0d bad=%0d exp %0d/0", dout_ones, dout_bad, hs); end
            n_tests++; if (led !== m[23:0] || n_valid !== 1 || n_err !== 0) begin n_fail++; $display("FAIL rnd_hold got %h/%0d/%0d exp %h/1/0", led, n_valid, n_err, m[23:0]); end
        end
    endtask

    task automatic test_wide();
        logic [63:0] m; int hs;
        clear_mon();
        drv(1, 1'b0, 2500);
        send_bits(1, 64'hDEADBEEF_01020304, 64, 1'b0, 105, m, hs);
        n_tests++; if (led2 !== 64'hDEADBEEF_01020304 || n_valid2 !== 1) begin n_fail++; $display("FAIL wide_capture got %h/%0d exp deadbeef01020304/1", led2, n_valid2); end
        n_tests++; if (pass2 !== 1'b1 || n_err2 !== 0) begin n_fail++; $display("FAIL wide_passthru got %b/%0d exp 1/0", pass2, n_err2); end
        send_bits(1, 64'($urandom), 8, 1'b1, 60, m, hs);
        n_tests++; if (dout_ones2 !== hs || dout_bad2 !== 0) begin n_fail++; $display("FAIL wide_forward got ones=%0d bad=%0d exp %0d/0", dout_ones2, dout_bad2, hs); end
    endtask

    initial begin
        clear_mon();
        last_data = '0; last_data2 = '0;
        test_reset();
        test_capture();
        test_passthru();
        test_truncated();
        test_high_max();
        test_sync_reset();
        test_random();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
